// File: rtl/amount_manager.sv
// Coin-operated charger money entry and charge-time countdown manager.
// Optional AM_CLEAR_KEY_EN: key code 4'hA in ENTRY clears the entered amount.
module amount_manager #(
  parameter int TICK_CYCLES   = 1000,
  parameter int MAX_MONEY     = 20,
  parameter int SECS_PER_UNIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pressed,
  input  logic [3:0] key_value,
  output logic [4:0] all_money,
  output logic [5:0] remaining_time,
  output logic       timing
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  localparam logic [0:0] ENTRY  = 1'b0;
  localparam logic [0:0] TIMING = 1'b1;

  logic [0:0]        state;
  logic              pressed_d;
  logic              start_d;
  logic              start_pending;
  logic [1:0]        digit_count;
  logic [TICK_W-1:0] tick_cnt;

  logic              key_edge;
  logic              start_edge;
  logic              start_req;
  logic              digit_ok;
  logic              clear_key;
  logic [6:0]        entered;
  logic [4:0]        next_money;

  function automatic logic [5:0] money_to_time(input logic [4:0] m);
    return 6'(32'(m) * SECS_PER_UNIT);
  endfunction

  assign key_edge   = pressed & ~pressed_d;
  assign start_edge = start & ~start_d;
  assign start_req  = start_edge | start_pending;
  assign digit_ok   = key_edge && (key_value <= 4'd9) && (digit_count < 2'd2);

`ifdef AM_CLEAR_KEY_EN
  assign clear_key = key_edge && (key_value == 4'hA);
`else
  assign clear_key = 1'b0;
`endif

  // Second digit shifts the first one up a decade; 99 fits in 7 bits before the cap.
  always_comb begin
    entered    = 7'd0;
    next_money = all_money;
    if (digit_count == 2'd0)
      entered = {3'd0, key_value};
    else
      entered = 7'(all_money) * 7'd10 + {3'd0, key_value};
    if (entered > 7'(MAX_MONEY))
      next_money = 5'(MAX_MONEY);
    else
      next_money = entered[4:0];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state          <= ENTRY;
      pressed_d      <= 1'b0;
      start_d        <= 1'b0;
      start_pending  <= 1'b0;
      digit_count    <= 2'd0;
      tick_cnt       <= '0;
      all_money      <= 5'd0;
      remaining_time <= 6'd0;
    end else begin
      pressed_d     <= pressed;
      start_d       <= start;
      start_pending <= 1'b0;
      if (state == ENTRY) begin
        if (clear_key) begin
          all_money      <= 5'd0;
          remaining_time <= 6'd0;
          digit_count    <= 2'd0;
        end else if (digit_ok) begin
          all_money      <= next_money;
          remaining_time <= money_to_time(next_money);
          digit_count    <= digit_count + 2'd1;
        end
        // A start arriving with a key waits one cycle so it sees the updated amount.
        if (key_edge)
          start_pending <= start_req;
        else if (start_req && (all_money != 5'd0)) begin
          state    <= TIMING;
          tick_cnt <= '0;
        end
      end else begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt       <= '0;
          remaining_time <= remaining_time - 6'd1;
          if (remaining_time == 6'd1) begin
            state       <= ENTRY;
            all_money   <= 5'd0;
            digit_count <= 2'd0;
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

  assign timing = (state == TIMING);

endmodule

// File: tb/tb_amount_manager.sv
// Self-checking bench for amount_manager: key-entry vector table plus countdown,
// start-edge, simultaneous key/start and asynchronous reset sequences.
module tb_amount_manager;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pressed;
  logic [3:0] key_value;
  logic [4:0] all_money;
  logic [5:0] remaining_time;
  logic       timing;

`ifdef AM_CLEAR_KEY_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct {
    string      name;
    bit         do_reset;
    logic [3:0] key;
    int         hold;
    int         exp_money;
    int         exp_rem;
  } vec_t;

  typedef struct {
    string name;
    int    money;
    int    rem;
    bit    tmg;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycles;

  always #5 clk = ~clk;

  amount_manager dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .pressed        (pressed),
    .key_value      (key_value),
    .all_money      (all_money),
    .remaining_time (remaining_time),
    .timing         (timing)
  );

  // Reset is asserted and released on falling edges, away from the active edge.
  task automatic doReset();
    start     = 1'b0;
    pressed   = 1'b0;
    key_value = 4'd0;
    rst_n     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  // One key press held for 'hold' cycles, then released for a cycle.
  task automatic applyStimulus(input logic [3:0] k, input int hold);
    pressed   = 1'b1;
    key_value = k;
    repeat (hold) @(negedge clk);
    pressed = 1'b0;
    @(negedge clk);
  endtask

  task automatic expectOut(input string name, input int m, input int r, input bit t);
    exp_t e;
    e.name  = name;
    e.money = m;
    e.rem   = r;
    e.tmg   = t;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    e = sb.pop_front();
    checks++;
    if (int'(all_money) != e.money || int'(remaining_time) != e.rem || timing != e.tmg) begin
      failures++;
      $display("[TB] FAIL %s: got money=%0d rem=%0d timing=%0b, want money=%0d rem=%0d timing=%0b",
               e.name, all_money, remaining_time, timing, e.money, e.rem, e.tmg);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    pressed   = 1'b0;
    key_value = 4'd0;

    vecs.push_back('{"reset_8",      1'b1, 4'd8,  1, 8,  16});
    vecs.push_back('{"then_9_cap",   1'b0, 4'd9,  1, 20, 40});
    vecs.push_back('{"third_ignore", 1'b0, 4'd1,  1, 20, 40});
    vecs.push_back('{"held_1",       1'b1, 4'd1,  5, 1,  2});
    vecs.push_back('{"then_5",       1'b0, 4'd5,  1, 15, 30});
    vecs.push_back('{"lead_zero",    1'b1, 4'd0,  1, 0,  0});
    vecs.push_back('{"zero_then_7",  1'b0, 4'd7,  3, 7,  14});
    vecs.push_back('{"third_3",      1'b0, 4'd3,  1, 7,  14});
    vecs.push_back('{"two",          1'b1, 4'd2,  1, 2,  4});
    vecs.push_back('{"exact_20",     1'b0, 4'd0,  1, 20, 40});
    vecs.push_back('{"two_b",        1'b1, 4'd2,  1, 2,  4});
    vecs.push_back('{"cap_21",       1'b0, 4'd1,  1, 20, 40});
    vecs.push_back('{"code_15",      1'b1, 4'd15, 1, 0,  0});
    vecs.push_back('{"digit_4",      1'b0, 4'd4,  1, 4,  8});
    vecs.push_back('{"code_10",      1'b0, 4'd10, 1, CLR ? 0 : 4, CLR ? 0 : 8});
    vecs.push_back('{"after_10",     1'b0, 4'd6,  1, CLR ? 6 : 20, CLR ? 12 : 40});

    doReset();
    expectOut("reset_state", 0, 0, 1'b0);
    checkOutput();

    foreach (vecs[i]) begin
      if (vecs[i].do_reset) doReset();
      expectOut(vecs[i].name, vecs[i].exp_money, vecs[i].exp_rem, 1'b0);
      applyStimulus(vecs[i].key, vecs[i].hold);
      checkOutput();
    end

    // Full countdown of 15 units = 30 s.
    doReset();
    applyStimulus(4'd1, 1);
    applyStimulus(4'd5, 1);
    start = 1'b1;
    @(negedge clk);
    expectOut("start_enter", 15, 30, 1'b1);
    checkOutput();
    cycles = 0;
    while (timing && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      if (cycles == 999) begin
        expectOut("before_tick", 15, 30, 1'b1);
        checkOutput();
      end
      if (cycles == 1000) begin
        expectOut("first_tick", 15, 29, 1'b1);
        checkOutput();
      end
    end
    checkInt("countdown_len", cycles, 30000);
    expectOut("countdown_end", 0, 0, 1'b0);
    checkOutput();
    start = 1'b0;
    expectOut("key_after_end", 3, 6, 1'b0);
    applyStimulus(4'd3, 1);
    checkOutput();

    // Start edge with nothing entered is ignored.
    doReset();
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    expectOut("start_zero", 0, 0, 1'b0);
    checkOutput();
    start = 1'b0;

    // Key and start rising together: key first, start one cycle later.
    doReset();
    pressed   = 1'b1;
    key_value = 4'd4;
    start     = 1'b1;
    @(negedge clk);
    expectOut("simul_key", 4, 8, 1'b0);
    checkOutput();
    @(negedge clk);
    expectOut("simul_start", 4, 8, 1'b1);
    checkOutput();
    pressed = 1'b0;
    @(negedge clk);
    expectOut("key_in_timing", 4, 8, 1'b1);
    applyStimulus(4'd9, 1);
    checkOutput();

    // Asynchronous reset mid-countdown clears outputs without a clock edge.
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    expectOut("async_reset", 0, 0, 1'b0);
    checkOutput();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    expectOut("after_reset", 0, 0, 1'b0);
    checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
